// File: rtl/adbg_jsp_apb_fifo_biu_if.sv
// APB slave bus bundle for the JTAG Serial Port bus interface.
// The master modport drives the request; the slave modport returns data and status.
interface adbg_jsp_apb_fifo_biu_if;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [2:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/adbg_jsp_apb_fifo_biu.sv
// JTAG Serial Port APB bus interface with RX (host->CPU) and TX (CPU->host) FIFOs.
// Optional feature: define JSP_RX_THRESHOLD_EN for a programmable RX interrupt threshold (reg 3).
module adbg_jsp_apb_fifo_biu #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           dbg_data_i,
  input  logic                 dbg_wr_i,
  output logic [7:0]           dbg_data_o,
  input  logic                 dbg_rd_i,
  output logic [CNT_W-1:0]     dbg_bytes_avail_o,
  output logic [CNT_W-1:0]     dbg_space_avail_o,
  adbg_jsp_apb_fifo_biu_if.slave apb,
  output logic                 int_o
);

  localparam int              AW      = $clog2(DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [CW-1:0]   FULL    = CW'(DEPTH);
  localparam int              CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [7:0] IIR_RX   = 8'hC4;
  localparam logic [7:0] IIR_THRE = 8'hC2;
  localparam logic [7:0] IIR_NONE = 8'hC1;

  typedef enum logic [2:0] {
    A_RBR   = 3'd0,
    A_IER   = 3'd1,
    A_IIR   = 3'd2,
    A_RXTL  = 3'd3,
    A_FCR   = 3'd4,
    A_LSR   = 3'd5,
    A_RXLVL = 3'd6,
    A_TXLVL = 3'd7
  } reg_addr_e;

  logic [7:0]    rx_mem [DEPTH];
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [1:0]    ier_q, ier_d;
  logic          oe_q, oe_d;
  logic          thre_q, thre_d;
  logic          int_q, int_d;
`ifdef JSP_RX_THRESHOLD_EN
  logic [CW-1:0] rxtl_q, rxtl_d;
`endif

  reg_addr_e addr;
  logic      wr_acc, rd_acc;
  logic      rx_empty, rx_full, tx_empty, tx_full;
  logic      rx_push, rx_pop, tx_push, tx_pop, thr_wr;
  logic      flush_rx, flush_tx;
  logic      rx_cond, rx_int, thre_int, thre_set, thre_clr;
  logic [7:0] iir, lsr, rbr;

  function automatic logic [CNT_W-1:0] sat_cnt(input int v);
    return (v > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(v);
  endfunction

  function automatic logic [7:0] sat8(input logic [CW-1:0] c);
    return (int'(c) > 255) ? 8'hFF : 8'(c);
  endfunction

  assign addr     = reg_addr_e'(apb.PADDR);
  assign wr_acc   = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign rd_acc   = apb.PSEL & apb.PENABLE & ~apb.PWRITE;

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL);
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == FULL);

  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign rx_pop   = rd_acc & (addr == A_RBR) & ~rx_empty;
  assign rx_push  = dbg_wr_i & (~rx_full | rx_pop);
  assign tx_pop   = dbg_rd_i & ~tx_empty;
  assign thr_wr   = wr_acc & (addr == A_RBR);
  assign tx_push  = thr_wr & (~tx_full | tx_pop);
  assign flush_rx = wr_acc & (addr == A_FCR) & apb.PWDATA[1];
  assign flush_tx = wr_acc & (addr == A_FCR) & apb.PWDATA[2];

  always_comb begin
    rx_wp_d  = rx_wp_q;
    rx_rp_d  = rx_rp_q;
    rx_cnt_d = rx_cnt_q;
    if (flush_rx) begin
      rx_wp_d  = '0;
      rx_rp_d  = '0;
      rx_cnt_d = '0;
    end else begin
      if (rx_push) rx_wp_d = rx_wp_q + AW'(1);
      if (rx_pop)  rx_rp_d = rx_rp_q + AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
        2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
        default: rx_cnt_d = rx_cnt_q;
      endcase
    end
  end

  always_comb begin
    tx_wp_d  = tx_wp_q;
    tx_rp_d  = tx_rp_q;
    tx_cnt_d = tx_cnt_q;
    if (flush_tx) begin
      tx_wp_d  = '0;
      tx_rp_d  = '0;
      tx_cnt_d = '0;
    end else begin
      if (tx_push) tx_wp_d = tx_wp_q + AW'(1);
      if (tx_pop)  tx_rp_d = tx_rp_q + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
        2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
        default: tx_cnt_d = tx_cnt_q;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and counts alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_wp_q] <= dbg_data_i;
    if (tx_push) tx_mem[tx_wp_q] <= apb.PWDATA;
  end

  always_comb begin
`ifdef JSP_RX_THRESHOLD_EN
    rx_cond = (rx_cnt_q >= rxtl_q);
`else
    rx_cond = ~rx_empty;
`endif
    rx_int   = rx_cond & ier_q[0];
    thre_int = thre_q & ier_q[1];
    iir      = rx_int ? IIR_RX : (thre_int ? IIR_THRE : IIR_NONE);
    lsr      = {1'b0, tx_empty, tx_empty, 3'b000, oe_q, ~rx_empty};
    rbr      = rx_empty ? 8'h00 : rx_mem[rx_rp_q];

    ier_d = ier_q;
    if (wr_acc && addr == A_IER) ier_d = apb.PWDATA[1:0];

    // A fresh overrun outranks a simultaneous LSR read so it is never lost.
    oe_d = oe_q;
    if (rd_acc && addr == A_LSR) oe_d = 1'b0;
    if (dbg_wr_i && rx_full && !rx_pop && !flush_rx) oe_d = 1'b1;

    thre_set = (~tx_empty & (tx_cnt_d == '0)) |
               (wr_acc & (addr == A_IER) & apb.PWDATA[1] & ~ier_q[1] & tx_empty);
    thre_clr = thr_wr | (rd_acc & (addr == A_IIR) & (iir == IIR_THRE));
    thre_d   = thre_set | (thre_q & ~thre_clr);

    int_d = rx_int | thre_int;

`ifdef JSP_RX_THRESHOLD_EN
    rxtl_d = rxtl_q;
    if (wr_acc && addr == A_RXTL) begin
      if (apb.PWDATA == 8'h00)              rxtl_d = CW'(1);
      else if (int'(apb.PWDATA) > DEPTH)    rxtl_d = FULL;
      else                                  rxtl_d = CW'(apb.PWDATA);
    end
`endif
  end

  always_comb begin
    apb.PRDATA  = 8'h00;
    apb.PSLVERR = 1'b0;
    if (rd_acc) begin
      case (addr)
        A_RBR:   apb.PRDATA = rbr;
        A_IER:   apb.PRDATA = {6'b0, ier_q};
        A_IIR:   apb.PRDATA = iir;
`ifdef JSP_RX_THRESHOLD_EN
        A_RXTL:  apb.PRDATA = sat8(rxtl_q);
`endif
        A_LSR:   apb.PRDATA = lsr;
        A_RXLVL: apb.PRDATA = sat8(rx_cnt_q);
        A_TXLVL: apb.PRDATA = sat8(tx_cnt_q);
        default: apb.PRDATA = 8'h00;
      endcase
    end else if (wr_acc) begin
      case (addr)
        A_RBR:                            apb.PSLVERR = tx_full & ~tx_pop;
        A_IIR, A_LSR, A_RXLVL, A_TXLVL:   apb.PSLVERR = 1'b1;
        default:                          apb.PSLVERR = 1'b0;
      endcase
    end
  end

  assign apb.PREADY        = 1'b1;
  assign dbg_data_o        = tx_empty ? 8'h00 : tx_mem[tx_rp_q];
  assign dbg_bytes_avail_o = sat_cnt(int'(tx_cnt_q));
  assign dbg_space_avail_o = sat_cnt(DEPTH - int'(rx_cnt_q));
  assign int_o             = int_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      ier_q    <= '0;
      oe_q     <= 1'b0;
      thre_q   <= 1'b0;
      int_q    <= 1'b0;
`ifdef JSP_RX_THRESHOLD_EN
      rxtl_q   <= CW'(1);
`endif
    end else begin
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      ier_q    <= ier_d;
      oe_q     <= oe_d;
      thre_q   <= thre_d;
      int_q    <= int_d;
`ifdef JSP_RX_THRESHOLD_EN
      rxtl_q   <= rxtl_d;
`endif
    end
  end

endmodule

// File: tb/tb_adbg_jsp_apb_fifo_biu.sv
// Self-checking bench: queue-based model compared every cycle, plus directed literal checks.
module tb_adbg_jsp_apb_fifo_biu;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [7:0]       dbg_data_i;
  logic             dbg_wr_i;
  logic [7:0]       dbg_data_o;
  logic             dbg_rd_i;
  logic [CNT_W-1:0] dbg_bytes_avail_o;
  logic [CNT_W-1:0] dbg_space_avail_o;
  logic             int_o;

  adbg_jsp_apb_fifo_biu_if apb_if ();

  adbg_jsp_apb_fifo_biu #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .dbg_data_i        (dbg_data_i),
    .dbg_wr_i          (dbg_wr_i),
    .dbg_data_o        (dbg_data_o),
    .dbg_rd_i          (dbg_rd_i),
    .dbg_bytes_avail_o (dbg_bytes_avail_o),
    .dbg_space_avail_o (dbg_space_avail_o),
    .apb               (apb_if),
    .int_o             (int_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_rx[$];
  logic [7:0] m_tx[$];
  logic [1:0] m_ier;
  bit         m_oe, m_thre, m_int;
  bit         model_valid = 0;
`ifdef JSP_RX_THRESHOLD_EN
  int         m_rxtl;
`endif

  function automatic bit m_rx_cond();
`ifdef JSP_RX_THRESHOLD_EN
    return m_rx.size() >= m_rxtl;
`else
    return m_rx.size() >= 1;
`endif
  endfunction

  function automatic logic [7:0] m_iir();
    if (m_rx_cond() && m_ier[0]) return 8'hC4;
    if (m_thre && m_ier[1])      return 8'hC2;
    return 8'hC1;
  endfunction

  function automatic logic [7:0] m_prdata(input logic [2:0] a);
    case (a)
      3'd0: return (m_rx.size() != 0) ? m_rx[0] : 8'h00;
      3'd1: return {6'b0, m_ier};
      3'd2: return m_iir();
`ifdef JSP_RX_THRESHOLD_EN
      3'd3: return 8'(m_rxtl);
`endif
      3'd5: return {1'b0, m_tx.size() == 0, m_tx.size() == 0, 3'b000, m_oe, m_rx.size() != 0};
      3'd6: return 8'(m_rx.size());
      3'd7: return 8'(m_tx.size());
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit m_pslverr(input logic [2:0] a);
    if (a == 3'd2 || a == 3'd5 || a == 3'd6 || a == 3'd7) return 1'b1;
    if (a == 3'd0 && m_tx.size() == DEPTH && !dbg_rd_i) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk_i) begin : model_update
    bit         acc, wr, rd, tx_had, t_set, t_clr;
    logic [2:0] a;
    logic [7:0] wd, iir_now;
    if (rst_i) begin
      m_rx.delete();
      m_tx.delete();
      m_ier = 2'b00;
      m_oe = 0;
      m_thre = 0;
      m_int = 0;
`ifdef JSP_RX_THRESHOLD_EN
      m_rxtl = 1;
`endif
      model_valid = 1;
    end else if (model_valid) begin
      acc     = apb_if.PSEL && apb_if.PENABLE;
      wr      = acc && apb_if.PWRITE;
      rd      = acc && !apb_if.PWRITE;
      a       = apb_if.PADDR;
      wd      = apb_if.PWDATA;
      iir_now = m_iir();
      tx_had  = m_tx.size() != 0;
      m_int   = (m_rx_cond() && m_ier[0]) || (m_thre && m_ier[1]);
      t_clr   = (wr && a == 3'd0) || (rd && a == 3'd2 && iir_now == 8'hC2);
      t_set   = wr && a == 3'd1 && wd[1] && !m_ier[1] && !tx_had;

      if (rd && a == 3'd5) m_oe = 0;
      if (wr && a == 3'd4 && wd[1]) m_rx.delete();
      else begin
        if (rd && a == 3'd0 && m_rx.size() != 0) void'(m_rx.pop_front());
        if (dbg_wr_i) begin
          if (m_rx.size() < DEPTH) m_rx.push_back(dbg_data_i);
          else m_oe = 1;
        end
      end

      if (wr && a == 3'd4 && wd[2]) m_tx.delete();
      else begin
        if (dbg_rd_i && m_tx.size() != 0) void'(m_tx.pop_front());
        if (wr && a == 3'd0 && m_tx.size() < DEPTH) m_tx.push_back(wd);
      end

      if (tx_had && m_tx.size() == 0) t_set = 1;
      m_thre = t_set || (m_thre && !t_clr);
      if (wr && a == 3'd1) m_ier = wd[1:0];
`ifdef JSP_RX_THRESHOLD_EN
      if (wr && a == 3'd3) m_rxtl = (wd == 0) ? 1 : ((int'(wd) > DEPTH) ? DEPTH : int'(wd));
`endif
    end
  end

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clk_i) begin
    if (model_valid && !rst_i) begin
      check("dbg_data_o", dbg_data_o, (m_tx.size() != 0) ? m_tx[0] : 8'h00);
      check("dbg_bytes_avail_o", dbg_bytes_avail_o, (m_tx.size() > 15) ? 15 : m_tx.size());
      check("dbg_space_avail_o", dbg_space_avail_o, ((DEPTH - m_rx.size()) > 15) ? 15 : (DEPTH - m_rx.size()));
      check("int_o", int_o, m_int);
      check("PREADY", apb_if.PREADY, 1);
      if (apb_if.PSEL && apb_if.PENABLE && !apb_if.PWRITE) begin
        check("PRDATA", apb_if.PRDATA, m_prdata(apb_if.PADDR));
        check("PSLVERR_rd", apb_if.PSLVERR, 0);
      end else if (apb_if.PSEL && apb_if.PENABLE) begin
        check("PRDATA_wr", apb_if.PRDATA, 0);
        check("PSLVERR_wr", apb_if.PSLVERR, m_pslverr(apb_if.PADDR));
      end else begin
        check("PRDATA_idle", apb_if.PRDATA, 0);
        check("PSLVERR_idle", apb_if.PSLVERR, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    dbg_wr_i   = 1'b1;
    dbg_data_i = b;
    step();
    dbg_wr_i   = 1'b0;
  endtask

  task automatic pop();
    dbg_rd_i = 1'b1;
    step();
    dbg_rd_i = 1'b0;
  endtask

  task automatic apb_xfer(input bit w, input logic [2:0] a, input logic [7:0] d,
                          output logic [7:0] rdata, output logic err,
                          input bit with_push = 0, input logic [7:0] pb = 8'h00);
    apb_if.PSEL    = 1'b1;
    apb_if.PENABLE = 1'b0;
    apb_if.PWRITE  = w;
    apb_if.PADDR   = a;
    apb_if.PWDATA  = d;
    step();
    apb_if.PENABLE = 1'b1;
    if (with_push) begin
      dbg_wr_i   = 1'b1;
      dbg_data_i = pb;
    end
    @(negedge clk_i);
    rdata = apb_if.PRDATA;
    err   = apb_if.PSLVERR;
    @(posedge clk_i);
    #1;
    apb_if.PSEL    = 1'b0;
    apb_if.PENABLE = 1'b0;
    apb_if.PWRITE  = 1'b0;
    dbg_wr_i       = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       e;
    rst_i          = 1'b1;
    dbg_data_i     = 8'h00;
    dbg_wr_i       = 1'b0;
    dbg_rd_i       = 1'b0;
    apb_if.PSEL    = 1'b0;
    apb_if.PENABLE = 1'b0;
    apb_if.PWRITE  = 1'b0;
    apb_if.PADDR   = 3'd0;
    apb_if.PWDATA  = 8'h00;
    repeat (3) step();
    rst_i = 1'b0;
    step();

    // Reset state
    check("rst_int_o", int_o, 0);
    check("rst_space", dbg_space_avail_o, 8);
    check("rst_bytes", dbg_bytes_avail_o, 0);
    check("rst_dbg_data", dbg_data_o, 0);
    check("rst_prdata", apb_if.PRDATA, 0);
    apb_xfer(0, 3'd5, 0, d, e); check("rst_lsr", d, 8'h60);
    apb_xfer(0, 3'd2, 0, d, e); check("rst_iir", d, 8'hC1);

    // RX overrun: nine bytes into an eight-entry FIFO
    for (int i = 1; i <= 9; i++) push(8'(i));
    check("rx_full_space", dbg_space_avail_o, 0);
    apb_xfer(0, 3'd6, 0, d, e); check("rxlvl_full", d, 8);
    apb_xfer(0, 3'd5, 0, d, e); check("lsr_oe", d, 8'h63);
    for (int i = 1; i <= 8; i++) begin
      apb_xfer(0, 3'd0, 0, d, e); check("rbr_data", d, 8'(i));
    end
    apb_xfer(0, 3'd0, 0, d, e); check("rbr_empty", d, 0); check("rbr_empty_err", e, 0);
    apb_xfer(0, 3'd5, 0, d, e); check("lsr_oe_clr", d, 8'h60);

    // THRE interrupt after the host drains TX
    apb_xfer(1, 3'd1, 8'h02, d, e);
    apb_xfer(1, 3'd0, 8'h41, d, e); check("thr_err", e, 0);
    check("tx_head", dbg_data_o, 8'h41);
    check("tx_bytes1", dbg_bytes_avail_o, 1);
    pop();
    check("int_lat0", int_o, 0);
    step();
    check("int_lat1", int_o, 1);
    apb_xfer(0, 3'd2, 0, d, e); check("iir_thre", d, 8'hC2);
    apb_xfer(0, 3'd2, 0, d, e); check("iir_none", d, 8'hC1);
    check("int_cleared", int_o, 0);

    // TX full and error responses
    for (int i = 0; i < 8; i++) begin
      apb_xfer(1, 3'd0, 8'h10 + 8'(i), d, e); check("thr_fill_err", e, 0);
    end
    apb_xfer(1, 3'd0, 8'hEE, d, e); check("thr_full_err", e, 1);
    apb_xfer(0, 3'd7, 0, d, e);     check("txlvl_full", d, 8);
    check("tx_bytes8", dbg_bytes_avail_o, 8);
    apb_xfer(1, 3'd5, 8'hFF, d, e); check("lsr_wr_err", e, 1);
    apb_xfer(0, 3'd5, 0, d, e);     check("lsr_unchanged", d, 8'h00);
    apb_xfer(1, 3'd3, 8'h05, d, e); check("rxtl_wr_err", e, 0);
    apb_xfer(1, 3'd1, 8'h00, d, e);
    for (int i = 0; i < 8; i++) begin
      check("tx_drain", dbg_data_o, 8'h10 + 8'(i));
      pop();
    end
    pop();  // pop on empty TX is ignored
    check("tx_empty_data", dbg_data_o, 0);

    // Concurrent push/pop at RX full, then flush beats push
    apb_xfer(1, 3'd3, 8'h01, d, e);
    for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
    apb_xfer(0, 3'd0, 0, d, e, 1, 8'hAB); check("rbr_pushpop", d, 8'hA0);
    apb_xfer(0, 3'd6, 0, d, e);           check("rxlvl_same", d, 8);
    apb_xfer(0, 3'd5, 0, d, e);           check("lsr_no_oe", d, 8'h61);
    apb_xfer(1, 3'd4, 8'h02, d, e, 1, 8'hCC);
    apb_xfer(0, 3'd6, 0, d, e);           check("rxlvl_flush", d, 0);
    apb_xfer(0, 3'd5, 0, d, e);           check("lsr_flush", d, 8'h60);

    // TX flush
    apb_xfer(1, 3'd0, 8'h55, d, e);
    apb_xfer(1, 3'd4, 8'h04, d, e);
    apb_xfer(0, 3'd7, 0, d, e);           check("txlvl_flush", d, 0);

`ifdef JSP_RX_THRESHOLD_EN
    apb_xfer(1, 3'd3, 8'h04, d, e);
    apb_xfer(0, 3'd3, 0, d, e);           check("rxtl_4", d, 4);
    apb_xfer(1, 3'd1, 8'h01, d, e);
    for (int i = 0; i < 3; i++) push(8'h30 + 8'(i));
    step();
    check("thr_int_below", int_o, 0);
    push(8'h33);
    step();
    check("thr_int_at", int_o, 1);
    apb_xfer(0, 3'd2, 0, d, e);           check("iir_rx", d, 8'hC4);
    apb_xfer(1, 3'd3, 8'h00, d, e);
    apb_xfer(0, 3'd3, 0, d, e);           check("rxtl_zero", d, 1);
    apb_xfer(1, 3'd3, 8'hC8, d, e);
    apb_xfer(0, 3'd3, 0, d, e);           check("rxtl_clamp", d, 8);
`else
    apb_xfer(0, 3'd3, 0, d, e);           check("reg3_zero", d, 0);
    apb_xfer(1, 3'd1, 8'h01, d, e);
    push(8'h30);
    step();
    check("rx_int", int_o, 1);
    apb_xfer(0, 3'd2, 0, d, e);           check("iir_rx", d, 8'hC4);
    apb_xfer(0, 3'd0, 0, d, e);           check("rbr_last", d, 8'h30);
    step();
    check("rx_int_clr", int_o, 0);
`endif

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
